// File: rtl/solver_pkg.sv
// Shared defaults and dispatch-state encoding for the fractal solver dispatcher.
package solver_pkg;

  localparam int DEF_LIMB_BITS       = 32;
  localparam int DEF_LIMB_INDEX_BITS = 6;
  localparam int DEF_ITER_BITS       = 16;
  localparam int DEF_TAG_BITS        = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } dispatch_state_e;

endpackage

// File: rtl/solver_dispatch_rr_arbiter.sv
// Rotating-priority arbiter: the pointer names the highest-priority requester and
// moves to just past the granted index whenever a grant is consumed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] grant_idx;

  // Scan from the farthest offset down so the nearest requester after ptr_q wins.
  always_comb begin
    grant    = '0;
    scan_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_idx = PW'((int'(ptr_q) + i) % N);
      if (req[scan_idx]) begin
        grant           = '0;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance && (|grant)) begin
      ptr_q <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/solver_dispatch.sv
// Job dispatcher / result collector for a bank of fractal solvers.
// Optional counters are enabled by defining SOLVER_DISPATCH_STATS_EN.
module solver_dispatch
  import solver_pkg::*;
#(
  parameter int NUM_SOLVERS     = 4,
  parameter int LIMB_BITS       = DEF_LIMB_BITS,
  parameter int LIMB_INDEX_BITS = DEF_LIMB_INDEX_BITS,
  parameter int ITER_BITS       = DEF_ITER_BITS,
  parameter int TAG_BITS        = DEF_TAG_BITS
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           job_val,
  output logic                           job_rdy,
  input  logic [LIMB_BITS-1:0]           job_re,
  input  logic [LIMB_BITS-1:0]           job_im,
  input  logic                           job_last,
  input  logic [TAG_BITS-1:0]            job_tag,
  output logic [NUM_SOLVERS-1:0]         slv_c_val,
  input  logic [NUM_SOLVERS-1:0]         slv_c_rdy,
  output logic [LIMB_BITS-1:0]           slv_c_re,
  output logic [LIMB_BITS-1:0]           slv_c_im,
  output logic                           slv_c_last,
  input  logic [NUM_SOLVERS-1:0]         slv_res_val,
  output logic [NUM_SOLVERS-1:0]         slv_res_rdy,
  input  logic [NUM_SOLVERS*ITER_BITS-1:0] slv_res_iter,
  output logic                           res_val,
  input  logic                           res_rdy,
  output logic [ITER_BITS-1:0]           res_iter,
  output logic [TAG_BITS-1:0]            res_tag,
  output logic [NUM_SOLVERS-1:0]         busy,
  output logic                           err_overlong
`ifdef SOLVER_DISPATCH_STATS_EN
  ,
  input  logic                           stat_clear,
  output logic [31:0]                    stat_jobs,
  output logic [31:0]                    stat_results
`endif
);

  localparam int SW = $clog2(NUM_SOLVERS);

  dispatch_state_e            state_q;
  logic [SW-1:0]              sel_q;
  logic [LIMB_INDEX_BITS-1:0] cnt_q;
  logic [NUM_SOLVERS-1:0]     busy_q;
  logic [NUM_SOLVERS-1:0]     busy_d;
  logic [TAG_BITS-1:0]        tag_q [NUM_SOLVERS];
  logic                       err_q;
  logic                       res_val_q;
  logic [ITER_BITS-1:0]       res_iter_q;
  logic [TAG_BITS-1:0]        res_tag_q;

  logic                       streaming;
  logic [NUM_SOLVERS-1:0]     sel_oh;
  logic                       beat_acc;
  logic                       last_acc;
  logic [NUM_SOLVERS-1:0]     disp_req;
  logic [NUM_SOLVERS-1:0]     disp_grant;
  logic [SW-1:0]              disp_idx;
  logic [NUM_SOLVERS-1:0]     res_req;
  logic [NUM_SOLVERS-1:0]     res_grant;
  logic [SW-1:0]              res_idx;
  logic                       can_load;
  logic                       res_hs;

  assign streaming = (state_q == STREAM);
  assign sel_oh    = NUM_SOLVERS'(1) << sel_q;
  assign beat_acc  = streaming & job_val & slv_c_rdy[sel_q];
  assign last_acc  = beat_acc & job_last;

  // While streaming, pinning the request to sel makes the last-beat advance land just past sel.
  assign disp_req = streaming ? sel_oh : ~busy_q;

  rr_arbiter #(.N(NUM_SOLVERS)) u_disp_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (disp_req),
    .advance (last_acc),
    .grant   (disp_grant)
  );

  assign res_req  = slv_res_val & busy_q;
  assign can_load = ~res_val_q | res_rdy;
  assign res_hs   = can_load & (|res_grant);

  rr_arbiter #(.N(NUM_SOLVERS)) u_res_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (res_req),
    .advance (res_hs),
    .grant   (res_grant)
  );

  always_comb begin
    disp_idx = '0;
    res_idx  = '0;
    for (int k = 0; k < NUM_SOLVERS; k++) begin
      if (disp_grant[k]) disp_idx = SW'(k);
      if (res_grant[k])  res_idx  = SW'(k);
    end
  end

  assign busy_d = (busy_q & ~(res_hs ? res_grant : '0)) | (last_acc ? sel_oh : '0);

  assign job_rdy     = streaming & slv_c_rdy[sel_q];
  assign slv_c_val   = (streaming && job_val) ? sel_oh : '0;
  assign slv_c_re    = streaming ? job_re : '0;
  assign slv_c_im    = streaming ? job_im : '0;
  assign slv_c_last  = streaming & job_last;
  assign slv_res_rdy = can_load ? res_grant : '0;

  assign res_val      = res_val_q;
  assign res_iter     = res_iter_q;
  assign res_tag      = res_tag_q;
  assign busy         = busy_q;
  assign err_overlong = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
      res_val_q  <= 1'b0;
      res_iter_q <= '0;
      res_tag_q  <= '0;
      for (int k = 0; k < NUM_SOLVERS; k++) tag_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_val && (|(~busy_q))) begin
            sel_q           <= disp_idx;
            tag_q[disp_idx] <= job_tag;
            cnt_q           <= '0;
            state_q         <= STREAM;
          end
        end
        STREAM: begin
          if (beat_acc) begin
            cnt_q <= cnt_q + 1'b1;
            // A non-final beat at the last counter value means the job cannot fit.
            if ((cnt_q == '1) && !job_last) err_q <= 1'b1;
            if (job_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      busy_q <= busy_d;

      if (res_hs) begin
        res_val_q  <= 1'b1;
        res_iter_q <= slv_res_iter[res_idx*ITER_BITS +: ITER_BITS];
        res_tag_q  <= tag_q[res_idx];
      end else if (res_rdy) begin
        res_val_q  <= 1'b0;
      end
    end
  end

`ifdef SOLVER_DISPATCH_STATS_EN
  logic [31:0] stat_jobs_q;
  logic [31:0] stat_results_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_jobs_q    <= '0;
      stat_results_q <= '0;
    end else if (stat_clear) begin
      stat_jobs_q    <= '0;
      stat_results_q <= '0;
    end else begin
      if (last_acc) stat_jobs_q    <= stat_jobs_q + 32'd1;
      if (res_hs)   stat_results_q <= stat_results_q + 32'd1;
    end
  end

  assign stat_jobs    = stat_jobs_q;
  assign stat_results = stat_results_q;
`endif

endmodule

// File: tb/tb_solver_dispatch.sv
// Self-checking bench for solver_dispatch: directed sequences plus a randomized run
// against a job/result scoreboard model.
module tb_solver_dispatch;

  localparam int N   = 4;
  localparam int LB  = 32;
  localparam int LIB = 2;
  localparam int IB  = 16;
  localparam int TB  = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            job_val, job_rdy, job_last;
  logic [LB-1:0]   job_re, job_im;
  logic [TB-1:0]   job_tag;
  logic [N-1:0]    slv_c_val, slv_c_rdy;
  logic [LB-1:0]   slv_c_re, slv_c_im;
  logic            slv_c_last;
  logic [N-1:0]    slv_res_val, slv_res_rdy;
  logic [N*IB-1:0] slv_res_iter;
  logic            res_val, res_rdy;
  logic [IB-1:0]   res_iter;
  logic [TB-1:0]   res_tag;
  logic [N-1:0]    busy;
  logic            err_overlong;

  int n_pass = 0;
  int n_total = 0;
  int beats_seen = 0;

  solver_dispatch #(
    .NUM_SOLVERS(N), .LIMB_BITS(LB), .LIMB_INDEX_BITS(LIB), .ITER_BITS(IB), .TAG_BITS(TB)
  ) dut (
    .clock(clock), .reset(reset),
    .job_val(job_val), .job_rdy(job_rdy), .job_re(job_re), .job_im(job_im),
    .job_last(job_last), .job_tag(job_tag),
    .slv_c_val(slv_c_val), .slv_c_rdy(slv_c_rdy), .slv_c_re(slv_c_re), .slv_c_im(slv_c_im),
    .slv_c_last(slv_c_last),
    .slv_res_val(slv_res_val), .slv_res_rdy(slv_res_rdy), .slv_res_iter(slv_res_iter),
    .res_val(res_val), .res_rdy(res_rdy), .res_iter(res_iter), .res_tag(res_tag),
    .busy(busy), .err_overlong(err_overlong)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset && (|(slv_c_val & slv_c_rdy))) beats_seen++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_job(input logic [15:0] tag, input int len, input int exp_sel, input int stall_beat);
    int w;
    int b0;
    b0 = beats_seen;
    job_val = 1'b1;
    job_tag = tag;
    for (int b = 0; b < len; b++) begin
      job_re   = {tag, 16'(b)};
      job_im   = ~job_re;
      job_last = (b == len - 1);
      if (b == stall_beat) begin
        slv_c_rdy[exp_sel] = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          check("stall_job_rdy", job_rdy, 0);
          tick();
        end
        slv_c_rdy[exp_sel] = 1'b1;
      end
      #1;
      w = 0;
      while (!job_rdy && w < 20) begin
        tick();
        w++;
      end
      if (!job_rdy) begin
        check("job_rdy_timeout", 0, 1);
        break;
      end
      check("c_val", slv_c_val, 64'(1) << exp_sel);
      check("c_data", {slv_c_re, slv_c_im}, {job_re, job_im});
      check("c_last", slv_c_last, job_last);
      tick();
    end
    job_val  = 1'b0;
    job_last = 1'b0;
    check("beat_count", 64'(beats_seen - b0), 64'(len));
  endtask

  task automatic give_result(input int k, input logic [15:0] iter);
    int w;
    slv_res_val[k] = 1'b1;
    slv_res_iter[k*IB +: IB] = iter;
    #1;
    w = 0;
    while (!slv_res_rdy[k] && w < 20) begin
      tick();
      w++;
    end
    if (!slv_res_rdy[k]) check("slv_res_rdy_timeout", 0, 1);
    tick();
    slv_res_val[k] = 1'b0;
  endtask

  task automatic run_random(input int ncyc);
    logic [N-1:0]  m_busy, elig;
    logic [15:0]   m_tag [N];
    logic [15:0]   m_iter [N];
    logic [15:0]   s_sum [N];
    int            s_dly [N];
    bit            s_pend [N];
    int            m_dptr, m_sel, hs_k, h_len, h_idx;
    bit            m_stream, m_rv, h_act, can_load;
    logic [15:0]   m_ri, m_rt, h_chk;
    m_busy = '0; m_dptr = 0; m_sel = 0; m_stream = 0; m_rv = 0; m_ri = 0; m_rt = 0;
    h_act = 0; h_len = 0; h_idx = 0; h_chk = 0;
    for (int k = 0; k < N; k++) begin
      m_tag[k] = 0; m_iter[k] = 0; s_sum[k] = 0; s_dly[k] = 0; s_pend[k] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      tick();
      check("rnd_busy", busy, m_busy);
      check("rnd_res_val", res_val, m_rv);
      if (m_rv) check("rnd_res", {res_iter, res_tag}, {m_ri, m_rt});
      check("rnd_err", err_overlong, 0);
      if (!h_act && $urandom_range(3) == 0) begin
        h_act = 1; h_len = $urandom_range(4, 1); h_idx = 0; h_chk = 0;
        job_tag = 16'($urandom);
      end
      job_val  = h_act && ($urandom_range(3) != 0);
      job_re   = $urandom;
      job_im   = $urandom;
      job_last = h_act && (h_idx == h_len - 1);
      slv_c_rdy = N'($urandom);
      res_rdy  = ($urandom_range(9) < 7);
      for (int k = 0; k < N; k++) begin
        slv_res_val[k] = (s_pend[k] && s_dly[k] == 0) || (!s_pend[k] && $urandom_range(9) == 0);
        slv_res_iter[k*IB +: IB] = s_sum[k];
      end
      #1;
      elig = slv_res_val & m_busy;
      can_load = !m_rv || res_rdy;
      if (!can_load || elig == 0) check("rnd_slv_res_rdy", slv_res_rdy, 0);
      else check("rnd_res_grant", ($onehot(slv_res_rdy) && ((slv_res_rdy & ~elig) == 0)), 1);
      hs_k = -1;
      for (int k = 0; k < N; k++) if (slv_res_val[k] && slv_res_rdy[k]) hs_k = k;
      if (!m_stream) begin
        check("rnd_idle_outputs", {job_rdy, slv_c_val}, 0);
        if (job_val && m_busy != '1) begin
          for (int i = 0; i < N; i++) begin
            if (!m_stream && !m_busy[(m_dptr + i) % N]) begin
              m_sel = (m_dptr + i) % N;
              m_stream = 1;
            end
          end
          m_tag[m_sel] = job_tag;
        end
      end else begin
        check("rnd_c_val", slv_c_val, job_val ? (64'(1) << m_sel) : 64'(0));
        check("rnd_job_rdy", job_rdy, slv_c_rdy[m_sel]);
        if (job_val && job_rdy) begin
          h_chk = h_chk + 16'(job_re ^ job_im) + 16'd1;
          h_idx++;
          if (job_last) begin
            m_busy[m_sel] = 1'b1;
            m_iter[m_sel] = h_chk;
            m_dptr = (m_sel + 1) % N;
            m_stream = 0;
            h_act = 0;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (slv_c_val[k] && slv_c_rdy[k]) begin
          s_sum[k] = s_sum[k] + 16'(slv_c_re ^ slv_c_im) + 16'd1;
          if (slv_c_last) begin
            s_pend[k] = 1;
            s_dly[k] = $urandom_range(4, 0);
          end
        end
      end
      if (hs_k >= 0) begin
        check("rnd_iter_route", s_sum[hs_k], m_iter[hs_k]);
        m_rv = 1; m_ri = s_sum[hs_k]; m_rt = m_tag[hs_k];
        m_busy[hs_k] = 1'b0; s_pend[hs_k] = 0; s_sum[hs_k] = 0;
      end else if (res_rdy) begin
        m_rv = 0;
      end
      for (int k = 0; k < N; k++) if (s_pend[k] && s_dly[k] > 0) s_dly[k]--;
    end
    job_val = 0; job_last = 0; slv_res_val = '0;
  endtask

  typedef struct {
    logic [15:0] tag;
    int          len;
    int          exp_sel;
    logic [3:0]  exp_busy;
  } job_vec_t;

  job_vec_t rr_tab [4];

  initial begin
    rr_tab[0] = '{tag: 16'h0011, len: 2, exp_sel: 0, exp_busy: 4'b0001};
    rr_tab[1] = '{tag: 16'h0012, len: 3, exp_sel: 1, exp_busy: 4'b0011};
    rr_tab[2] = '{tag: 16'h0013, len: 1, exp_sel: 2, exp_busy: 4'b0111};
    rr_tab[3] = '{tag: 16'h0014, len: 2, exp_sel: 3, exp_busy: 4'b1111};

    reset = 1'b1; job_val = 0; job_re = 0; job_im = 0; job_last = 0; job_tag = 0;
    slv_c_rdy = '1; slv_res_val = '0; slv_res_iter = '0; res_rdy = 1'b1;
    tick(); tick();
    check("reset_ctrl", {job_rdy, slv_c_val, slv_c_last, slv_res_rdy, res_val, busy, err_overlong}, 0);
    check("reset_data", {res_iter, res_tag, slv_c_re}, 0);
    reset = 1'b0;
    tick();

    // Single job into an idle bank.
    send_job(16'h00A5, 4, 0, -1);
    check("single_busy", busy, 4'b0001);
    give_result(0, 16'd123);
    check("single_res", {res_val, res_iter, res_tag}, {1'b1, 16'd123, 16'h00A5});
    check("single_busy_clr", busy, 0);
    tick();
    check("single_res_drop", res_val, 0);

    // Reset in the middle of a job.
    job_val = 1; job_tag = 16'h0077; job_re = 1; job_im = 2; job_last = 0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("midrst_outputs", {job_rdy, slv_c_val, busy, res_val, err_overlong, slv_c_re}, 0);
    tick();
    reset = 1'b0; job_val = 0;
    tick();
    check("midrst_busy", busy, 0);

    // Result from a solver with no job is ignored.
    slv_res_val[1] = 1'b1; slv_res_iter[1*IB +: IB] = 16'd999;
    #1;
    check("stray_rdy", slv_res_rdy, 0);
    tick(); tick();
    check("stray_res_val", res_val, 0);
    slv_res_val[1] = 1'b0;

    // Round-robin fill of the bank.
    for (int i = 0; i < 4; i++) begin
      send_job(rr_tab[i].tag, rr_tab[i].len, rr_tab[i].exp_sel, -1);
      check("rr_busy", busy, rr_tab[i].exp_busy);
    end

    // Fifth job waits until solver 2 frees up.
    job_val = 1; job_tag = 16'h0015; job_re = 5; job_im = 6; job_last = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_bank_job_rdy", job_rdy, 0);
      tick();
    end
    give_result(2, 16'd200);
    check("free2_res", {res_val, res_iter, res_tag}, {1'b1, 16'd200, 16'h0013});
    send_job(16'h0015, 2, 2, -1);
    check("job5_busy", busy, 4'b1111);

    // Solvers 1 and 3 compete; pointer sits past solver 2 so 3 wins first.
    slv_res_val[1] = 1; slv_res_iter[1*IB +: IB] = 16'd301;
    slv_res_val[3] = 1; slv_res_iter[3*IB +: IB] = 16'd303;
    #1;
    check("cont_grant1", slv_res_rdy, 4'b1000);
    tick();
    slv_res_val[3] = 0;
    #1;
    check("cont_res1", {res_val, res_iter, res_tag}, {1'b1, 16'd303, 16'h0014});
    check("cont_grant2", slv_res_rdy, 4'b0010);
    tick();
    slv_res_val[1] = 0;
    check("cont_res2", {res_val, res_iter, res_tag}, {1'b1, 16'd301, 16'h0012});
    tick();
    check("cont_drain", {res_val, busy}, {1'b0, 4'b0101});

    // Host backpressure holds the output register.
    res_rdy = 0;
    slv_res_val[0] = 1; slv_res_iter[0*IB +: IB] = 16'd400;
    slv_res_val[2] = 1; slv_res_iter[2*IB +: IB] = 16'd402;
    #1;
    check("bp_grant", slv_res_rdy, 4'b0100);
    tick();
    slv_res_val[2] = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_hold", {res_val, res_iter, res_tag, slv_res_rdy}, {1'b1, 16'd402, 16'h0015, 4'b0000});
      tick();
    end
    res_rdy = 1;
    #1;
    check("bp_release_grant", slv_res_rdy, 4'b0001);
    tick();
    slv_res_val[0] = 0;
    check("bp_no_bubble", {res_val, res_iter, res_tag}, {1'b1, 16'd400, 16'h0011});
    tick();
    check("bp_drain", {res_val, busy}, 0);

    // Solver stalls mid-stream; dispatch pointer is now at solver 3.
    send_job(16'h0021, 4, 3, 2);
    check("stall_busy", busy, 4'b1000);
    check("pre_overlong_err", err_overlong, 0);

    // Five limbs with a four-limb limit.
    send_job(16'h0031, 5, 0, -1);
    check("overlong_err", err_overlong, 1);
    check("overlong_busy", busy, 4'b1001);
    tick(); tick(); tick();
    check("overlong_sticky", err_overlong, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_clears_err", {err_overlong, busy}, 0);

    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
